// File: rtl/spike_dispatcher_pkg.sv
// Shared definitions for the spike dispatcher and the spike-ID queue it drains.
package spike_dispatcher_pkg;

  localparam int SPIKE_ID_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_POP  = 2'd1,
    ST_LOAD = 2'd2,
    ST_EMIT = 2'd3
  } disp_state_e;

endpackage

// File: rtl/spike_dispatcher.sv
// Pops source-neuron IDs from the spike queue and expands each into FANOUT
// (src, dst) synapse requests over a valid/ready handshake.
//
// state | meaning
// IDLE  | waiting for enable_i & q_valid_i
// POP   | read strobe to the queue (one cycle)
// LOAD  | queue read data valid; capture source ID, clear dst counter
// EMIT  | presenting requests dst = 0 .. FANOUT-1
module spike_dispatcher
  import spike_dispatcher_pkg::*;
#(
  parameter int FANOUT = 16,
  parameter int DST_W  = $clog2(FANOUT),
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable_i,
  input  logic                  q_valid_i,
  output logic                  q_read_o,
  input  logic [SPIKE_ID_W-1:0] q_data_i,
  output logic                  syn_valid_o,
  input  logic                  syn_ready_i,
  output logic [SPIKE_ID_W-1:0] syn_src_o,
  output logic [DST_W-1:0]      syn_dst_o,
  output logic                  syn_last_o,
  output logic                  busy_o,
  output logic [CNT_W-1:0]      spike_cnt_o
);

  disp_state_e           state_q, state_d;
  logic [SPIKE_ID_W-1:0] src_q, src_d;
  logic [DST_W-1:0]      dst_q, dst_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  last;

  assign last = (dst_q == DST_W'(FANOUT - 1));

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: if (enable_i && q_valid_i) state_d = ST_POP;
      ST_POP:  state_d = ST_LOAD;
      ST_LOAD: begin
        src_d   = q_data_i;
        dst_d   = '0;
        state_d = ST_EMIT;
      end
      ST_EMIT: begin
        if (syn_ready_i) begin
          if (last) begin
            cnt_d = cnt_q + 1'b1;
            // q_valid_i is only trusted here and in IDLE: the queue's
            // occupancy lags the read strobe by a cycle.
            state_d = (enable_i && q_valid_i) ? ST_POP : ST_IDLE;
          end else begin
            dst_d = dst_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
    end
  end

  // Every output is a decode of registered state; nothing passes through
  // from syn_ready_i or q_valid_i.
  assign q_read_o    = (state_q == ST_POP);
  assign syn_valid_o = (state_q == ST_EMIT);
  assign syn_src_o   = src_q;
  assign syn_dst_o   = dst_q;
  assign syn_last_o  = (state_q == ST_EMIT) && last;
  assign busy_o      = (state_q != ST_IDLE);
  assign spike_cnt_o = cnt_q;

endmodule

// File: tb/tb_spike_dispatcher.sv
// Directed bench for spike_dispatcher: queue model with one-cycle read latency,
// handshake checker, table of single-spike vectors, and multi-cycle corner cases.
module tb_spike_dispatcher;

  localparam int FANOUT = 16;
  localparam int DST_W  = 4;
  localparam int CNT_W  = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             enable_i = 1'b0;
  logic             q_valid_i = 1'b0;
  logic [7:0]       q_data_i = 8'hEE;
  logic             syn_ready_i = 1'b0;
  logic             q_read_o, syn_valid_o, syn_last_o, busy_o;
  logic [7:0]       syn_src_o;
  logic [DST_W-1:0] syn_dst_o;
  logic [CNT_W-1:0] spike_cnt_o;

  spike_dispatcher #(.FANOUT(FANOUT), .DST_W(DST_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .enable_i(enable_i), .q_valid_i(q_valid_i),
    .q_read_o(q_read_o), .q_data_i(q_data_i), .syn_valid_o(syn_valid_o),
    .syn_ready_i(syn_ready_i), .syn_src_o(syn_src_o), .syn_dst_o(syn_dst_o),
    .syn_last_o(syn_last_o), .busy_o(busy_o), .spike_cnt_o(spike_cnt_o)
  );

  // Narrow instance for counter wrap: FANOUT=2, CNT_W=4.
  logic       w_qv = 1'b0;
  logic [7:0] w_data = 8'h11;
  logic       w_rdy = 1'b1;
  logic       w_qread, w_valid, w_last, w_busy;
  logic [7:0] w_src;
  logic [0:0] w_dst;
  logic [3:0] w_cnt;

  spike_dispatcher #(.FANOUT(2), .DST_W(1), .CNT_W(4)) u_wrap (
    .clk(clk), .rst_n(rst_n), .enable_i(1'b1), .q_valid_i(w_qv),
    .q_read_o(w_qread), .q_data_i(w_data), .syn_valid_o(w_valid),
    .syn_ready_i(w_rdy), .syn_src_o(w_src), .syn_dst_o(w_dst),
    .syn_last_o(w_last), .busy_o(w_busy), .spike_cnt_o(w_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Queue model: data appears during the cycle after the read strobe.
  logic [7:0] fifo[$];
  logic [7:0] popped = 8'h00;
  bit         load_next = 1'b0;

  initial forever begin
    @(posedge clk);
    #1;
    if (load_next) begin
      q_data_i  = popped;
      load_next = 1'b0;
    end else begin
      q_data_i = 8'hEE;
    end
    if (q_read_o && fifo.size() != 0) begin
      popped    = fifo.pop_front();
      load_next = 1'b1;
    end
  end

  initial forever begin
    @(negedge clk);
    q_valid_i = (fifo.size() != 0);
  end

  logic [3:0] rdy_pat = 4'hF;
  initial forever begin
    @(posedge clk);
    #1;
    syn_ready_i = rdy_pat[cyc % 4];
  end

  // Handshake checker.
  logic [7:0]       exp_ids[$];
  logic [7:0]       cur_src = 8'h00;
  int               exp_dst = 0;
  int               hs = 0, bursts = 0, pops = 0, busy_cyc = 0;
  bit               prev_stall = 1'b0, prev_qr = 1'b0;
  logic [7:0]       st_src;
  logic [DST_W-1:0] st_dst;
  logic             st_last;
  int               pop_cyc[$];

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      exp_dst    = 0;
      prev_stall = 1'b0;
      prev_qr    = 1'b0;
    end else begin
      if (busy_o) busy_cyc++;
      if (q_read_o) begin
        pops++;
        pop_cyc.push_back(cyc);
        chk("double_pop", {31'b0, prev_qr}, 32'd0);
      end
      prev_qr = q_read_o;
      if (prev_stall) begin
        chk("stall_valid", {31'b0, syn_valid_o}, 32'd1);
        chk("stall_src", {24'b0, syn_src_o}, {24'b0, st_src});
        chk("stall_dst", {28'b0, syn_dst_o}, {28'b0, st_dst});
        chk("stall_last", {31'b0, syn_last_o}, {31'b0, st_last});
      end
      if (syn_valid_o && syn_ready_i) begin
        if (exp_dst == 0 && exp_ids.size() != 0) cur_src = exp_ids.pop_front();
        chk("hs_src", {24'b0, syn_src_o}, {24'b0, cur_src});
        chk("hs_dst", {28'b0, syn_dst_o}, exp_dst);
        chk("hs_last", {31'b0, syn_last_o}, (exp_dst == FANOUT - 1) ? 32'd1 : 32'd0);
        hs++;
        if (exp_dst == FANOUT - 1) begin
          exp_dst = 0;
          bursts++;
        end else begin
          exp_dst++;
        end
      end
      prev_stall = syn_valid_o && !syn_ready_i;
      st_src     = syn_src_o;
      st_dst     = syn_dst_o;
      st_last    = syn_last_o;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_busy(input logic lvl, input int max, input string name);
    int i = 0;
    while (busy_o !== lvl && i < max) begin
      @(negedge clk);
      i++;
    end
    chk(name, {31'b0, busy_o}, {31'b0, lvl});
  endtask

  task automatic push(input logic [7:0] id);
    fifo.push_back(id);
    exp_ids.push_back(id);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_qread"}, {31'b0, q_read_o}, 32'd0);
    chk({tag, "_valid"}, {31'b0, syn_valid_o}, 32'd0);
    chk({tag, "_src"}, {24'b0, syn_src_o}, 32'd0);
    chk({tag, "_dst"}, {28'b0, syn_dst_o}, 32'd0);
    chk({tag, "_last"}, {31'b0, syn_last_o}, 32'd0);
    chk({tag, "_busy"}, {31'b0, busy_o}, 32'd0);
    chk({tag, "_cnt"}, {16'b0, spike_cnt_o}, 32'd0);
  endtask

  typedef struct {
    logic [7:0] id;
    logic [3:0] pat;        // ready pattern, bit (cycle % 4)
    bit         gate_first; // hold enable_i low with the queue non-empty first
    int         exp_cnt;
  } vec_t;

  vec_t tbl[4];

  initial begin
    int p0, h0, b0, bc0, i;

    tbl[0] = '{id: 8'h2A, pat: 4'b1111, gate_first: 1'b0, exp_cnt: 1};
    tbl[1] = '{id: 8'h00, pat: 4'b1001, gate_first: 1'b0, exp_cnt: 2};
    tbl[2] = '{id: 8'hFF, pat: 4'b0101, gate_first: 1'b1, exp_cnt: 3};
    tbl[3] = '{id: 8'h80, pat: 4'b0011, gate_first: 1'b0, exp_cnt: 4};

    #1 rst_n = 1'b0;
    tick(3);
    chk_all_zero("reset");
    @(negedge clk);
    rst_n    = 1'b1;
    enable_i = 1'b1;
    tick(2);

    for (int v = 0; v < 4; v++) begin
      rdy_pat = tbl[v].pat;
      p0 = pops; h0 = hs; b0 = bursts;
      if (tbl[v].gate_first) begin
        enable_i = 1'b0;
        push(tbl[v].id);
        tick(10);
        chk("gated_pops", pops, p0);
        chk("gated_busy", {31'b0, busy_o}, 32'd0);
        enable_i = 1'b1;
      end else begin
        push(tbl[v].id);
      end
      wait_busy(1'b1, 10, "vec_start");
      wait_busy(1'b0, 400, "vec_done");
      chk("vec_handshakes", hs - h0, 32'd16);
      chk("vec_bursts", bursts - b0, 32'd1);
      chk("vec_pops", pops - p0, 32'd1);
      chk("vec_cnt", {16'b0, spike_cnt_o}, tbl[v].exp_cnt);
    end

    // Back-to-back: three queued IDs, ready held high.
    rdy_pat = 4'hF;
    tick(2);
    pop_cyc.delete();
    bc0 = busy_cyc; b0 = bursts;
    push(8'h01); push(8'h02); push(8'h03);
    wait_busy(1'b1, 10, "b2b_start");
    wait_busy(1'b0, 200, "b2b_done");
    chk("b2b_cycles", busy_cyc - bc0, 32'd54);
    chk("b2b_bursts", bursts - b0, 32'd3);
    chk("b2b_pops", pop_cyc.size(), 32'd3);
    if (pop_cyc.size() == 3) begin
      chk("b2b_gap1", pop_cyc[1] - pop_cyc[0], 32'd18);
      chk("b2b_gap2", pop_cyc[2] - pop_cyc[1], 32'd18);
    end
    chk("b2b_cnt", {16'b0, spike_cnt_o}, 32'd7);

    // Enable dropped mid-burst.
    p0 = pops; h0 = hs; b0 = bursts;
    push(8'h55); push(8'h66);
    wait_busy(1'b1, 10, "en_start");
    i = 0;
    while (hs - h0 < 3 && i < 50) begin
      @(negedge clk);
      i++;
    end
    enable_i = 1'b0;
    wait_busy(1'b0, 200, "en_done");
    chk("en_bursts", bursts - b0, 32'd1);
    chk("en_pops", pops - p0, 32'd1);
    chk("en_qvalid", {31'b0, q_valid_i}, 32'd1);
    tick(8);
    chk("en_idle_pops", pops - p0, 32'd1);
    chk("en_idle_busy", {31'b0, busy_o}, 32'd0);
    enable_i = 1'b1;
    wait_busy(1'b1, 10, "en_resume");
    wait_busy(1'b0, 200, "en_drain");
    chk("en_bursts2", bursts - b0, 32'd2);
    chk("en_cnt", {16'b0, spike_cnt_o}, 32'd9);

    // Reset mid-burst at dst = 7.
    push(8'h77); push(8'h78);
    i = 0;
    while (!(syn_valid_o && syn_dst_o == 4'd7) && i < 100) begin
      @(negedge clk);
      i++;
    end
    chk("rst_reach_dst7", {28'b0, syn_dst_o}, 32'd7);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("rst_mid");
    tick(2);
    b0 = bursts; p0 = pops;
    rst_n = 1'b1;
    wait_busy(1'b1, 10, "rst_restart");
    wait_busy(1'b0, 200, "rst_done");
    chk("rst_bursts", bursts - b0, 32'd1);
    chk("rst_pops", pops - p0, 32'd1);
    chk("rst_cnt", {16'b0, spike_cnt_o}, 32'd1);
    chk("rst_fifo_empty", fifo.size(), 32'd0);

    // Counter wrap on the narrow instance: 17 spikes into a 4-bit counter.
    begin
      int wp = 0;
      @(negedge clk);
      w_qv = 1'b1;
      i = 0;
      while (wp < 17 && i < 400) begin
        @(negedge clk);
        if (w_qread) wp++;
        if (wp == 17) w_qv = 1'b0;
        i++;
      end
      w_qv = 1'b0;
      chk("wrap_pops", wp, 32'd17);
      i = 0;
      while (w_busy && i < 20) begin
        @(negedge clk);
        i++;
      end
      chk("wrap_busy", {31'b0, w_busy}, 32'd0);
      chk("wrap_cnt", {28'b0, w_cnt}, 32'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/spike_dispatcher.md
# spike_dispatcher

Downstream consumer of the 8-bit spike-ID queue: pops one source-neuron ID at a time and expands it into a burst of FANOUT synapse requests (source, destination) toward the weight/accumulate stage over a valid/ready handshake. Owns the queue's read strobe. Accounts for the queue SRAM's one-cycle read latency. Keeps a running count of dispatched spikes for firmware.

## Interface
Parameters:
- FANOUT, 16: destinations per source spike; legal range 2..256.
- DST_W, $clog2(FANOUT): destination index width.
- CNT_W, 16: width of dispatched-spike counter.

Ports (clock and reset: one clock; reset is asynchronous and active-low):
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enable_i  in  1  when 0, no new pop starts; in-progress burst completes.
- q_valid_i  in  1  queue non-empty.
- q_read_o  out  1  single-cycle pop strobe to queue.
- q_data_i  in  8  queue read data; valid exactly one cycle after q_read_o.
- syn_valid_o  out  1  synapse request valid.
- syn_ready_i  in  1  downstream accepts request.
- syn_src_o  out  8  source neuron ID of current burst.
- syn_dst_o  out  DST_W  destination index.
- syn_last_o  out  1  high on final request of burst (dst = FANOUT-1).
- busy_o  out  1  FSM not in IDLE.
- spike_cnt_o  out  CNT_W  spikes whose burst fully completed; wraps.

## Operation
- States: IDLE, POP, LOAD, EMIT.
- IDLE: if enable_i & q_valid_i -> POP; else stay.
- POP: q_read_o=1 for this cycle only -> LOAD.
- LOAD: capture q_data_i into src register, dst counter <= 0 -> EMIT. q_read_o=0.
- EMIT: syn_valid_o=1, syn_src_o=src reg, syn_dst_o=dst counter, syn_last_o=(dst==FANOUT-1). On syn_valid_o & syn_ready_i: if not last, dst+1, stay; if last, spike_cnt_o+1, then -> POP if enable_i & q_valid_i, else -> IDLE.
- Outputs syn_* hold stable while syn_valid_o & ~syn_ready_i (AXI-style; valid never drops without acceptance).
- q_read_o only asserted in POP; never two pops without an intervening LOAD. q_valid_i sampled only in IDLE and on last handshake, never in POP/LOAD (queue size updates one cycle after read).
- enable_i deassert during EMIT: burst finishes all FANOUT requests, then IDLE.
- spike_cnt_o wraps modulo 2^CNT_W without flag.
- Reset (any time, including mid-burst): state IDLE, q_read_o=0, syn_valid_o=0, syn_src_o=0, syn_dst_o=0, syn_last_o=0, busy_o=0, spike_cnt_o=0. Partial burst is dropped; popped ID lost (accepted).

## Timing
- Pop-to-first-request: q_read_o at cycle t, q_data_i sampled at t+1, syn_valid_o first high at t+2.
- With syn_ready_i held high: burst = FANOUT cycles; back-to-back spikes cost FANOUT+2 cycles each (POP, LOAD, FANOUT EMIT).
- spike_cnt_o increments on the cycle after the last handshake edge.
- All outputs registered or decoded from registered state only; no combinational path from syn_ready_i or q_valid_i to any output.

## Structure
- Shared package: state encoding enum (IDLE/POP/LOAD/EMIT), SPIKE_ID_W=8 constant shared with the queue.
- Single module, no sub-module; dst counter and FSM inline.

## Test plan
- Single spike: push ID 0x2A, ready=1 -> q_read_o one cycle, then 16 requests src=0x2A dst=0..15, last only at dst=15, spike_cnt_o=1, busy_o returns 0.
- Backpressure: ready toggles 1,0,0,1... -> syn_* stable while stalled, no dst skipped or duplicated, exactly 16 handshakes.
- Back-to-back: queue IDs 0x01,0x02,0x03 preloaded -> three bursts, second q_read_o exactly 1 cycle after first burst's last handshake, 54 cycles total with ready=1.
- Enable gating: enable_i=0 with queue non-empty -> q_read_o never asserts; drop enable mid-burst -> burst completes, then IDLE with queue still non-empty.
- Reset mid-burst: rst_n low at dst=7 -> all outputs 0 asynchronously, spike_cnt_o=0; after release, next queued ID dispatched from dst=0.
- Counter wrap: CNT_W=4, 17 spikes -> spike_cnt_o reads 1.
